// File: rtl/rst_wb_arbiter_pkg.sv
// Shared types and sizing for the RST writeback arbiter and its per-FU result buffers.
package rst_wb_arbiter_pkg;

    localparam int NUM_FU = 3;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int TAG_W  = 2;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [TAG_W-1:0]  tag_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        word_t            data;
        logic             spec;
        logic             killed;
    } wb_entry_t;

    function automatic tag_t rr_next(tag_t t);
        return (t == tag_t'(NUM_FU - 1)) ? '0 : t + tag_t'(1);
    endfunction

endpackage

// File: rtl/rst_wb_fifo.sv
// Per-FU circular result buffer; flush marks held speculative entries killed, resolve clears spec.
module rst_wb_fifo
    import rst_wb_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    input  logic             flush,
    input  logic             resolved,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            // Stale slots get marked too; harmless since a push overwrites the whole entry.
            for (int k = 0; k < DEPTH; k++) begin
                if (flush) begin
                    if (mem[k].spec) begin
                        mem[k].killed <= 1'b1;
                    end
                end else if (resolved) begin
                    mem[k].spec <= 1'b0;
                end
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/rst_wb_arbiter.sv
// Collects FU results into per-FU buffers and round-robins them onto the RST/regfile writeback port.
module rst_wb_arbiter
    import rst_wb_arbiter_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_FU-1:0]         fu_valid,
    output logic [NUM_FU-1:0]         fu_ready,
    input  logic [NUM_FU*REG_W-1:0]   fu_rd,
    input  logic [NUM_FU*DATA_W-1:0]  fu_data,
    input  logic [NUM_FU-1:0]         fu_spec,
    input  logic                      flush,
    input  logic                      resolved,
    output logic                      wb_write,
    output logic [REG_W-1:0]          wb_sel,
    output logic [DATA_W-1:0]         wb_data,
    output logic [TAG_W-1:0]          wb_tag,
    output logic                      busy
);

    wb_entry_t        head       [NUM_FU];
    wb_entry_t        push_entry [NUM_FU];
    logic [CNT_W-1:0] count      [NUM_FU];
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [NUM_FU-1:0] live;
    logic [NUM_FU-1:0] kill_pop;
    logic [NUM_FU-1:0] held;

    tag_t rr_ptr;
    tag_t grant_idx;
    logic grant_found;
    logic grant_valid;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        assign fu_ready[g] = (count[g] < CNT_W'(DEPTH));
        assign held[g]     = (count[g] != '0);
        assign live[g]     = held[g] && !head[g].killed;
        assign kill_pop[g] = held[g] && head[g].killed;

        // A speculative result arriving with flush is swallowed: handshake completes, nothing stored.
        assign push[g] = fu_valid[g] & fu_ready[g] & ~(flush & fu_spec[g]);
        assign pop[g]  = kill_pop[g] | (grant_valid && (grant_idx == tag_t'(g)));

        assign push_entry[g] = {fu_rd[g*REG_W +: REG_W],
                                fu_data[g*DATA_W +: DATA_W],
                                fu_spec[g] & ~resolved,
                                1'b0};

        rst_wb_fifo u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (push[g]),
            .push_entry (push_entry[g]),
            .pop        (pop[g]),
            .flush      (flush),
            .resolved   (resolved),
            .head       (head[g]),
            .count      (count[g])
        );
    end

    always_comb begin
        logic [2:0] sum;
        sum         = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, rr_ptr} + 3'(k);
            if (sum >= 3'(NUM_FU)) begin
                sum = sum - 3'(NUM_FU);
            end
            if (!grant_found && live[sum[TAG_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[TAG_W-1:0];
            end
        end
        // The winner's head is about to be killed by this flush, so it must not write back.
        grant_valid = grant_found && !(flush && head[grant_idx].spec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            wb_write <= 1'b0;
            wb_sel   <= '0;
            wb_data  <= '0;
            wb_tag   <= '0;
        end else if (grant_valid) begin
            rr_ptr   <= rr_next(grant_idx);
            wb_write <= 1'b1;
            wb_sel   <= head[grant_idx].rd;
            wb_data  <= head[grant_idx].data;
            wb_tag   <= grant_idx;
        end else begin
            wb_write <= 1'b0;
        end
    end

    assign busy = (|held) | wb_write;

endmodule

// File: tb/tb_rst_wb_arbiter.sv
// Bench for rst_wb_arbiter: vector table, directed flush/resolve sequences and a random run vs a queue model.
module tb_rst_wb_arbiter;
    import rst_wb_arbiter_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_FU-1:0]        fu_valid = '0;
    logic [NUM_FU-1:0]        fu_ready;
    logic [NUM_FU*REG_W-1:0]  fu_rd = '0;
    logic [NUM_FU*DATA_W-1:0] fu_data = '0;
    logic [NUM_FU-1:0]        fu_spec = '0;
    logic                     flush = 1'b0;
    logic                     resolved = 1'b0;
    logic                     wb_write;
    logic [REG_W-1:0]         wb_sel;
    logic [DATA_W-1:0]        wb_data;
    logic [TAG_W-1:0]         wb_tag;
    logic                     busy;

    int checks = 0;
    int failures = 0;
    logic [NUM_FU-1:0] rdy_pre;

    rst_wb_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fu_valid (fu_valid),
        .fu_ready (fu_ready),
        .fu_rd    (fu_rd),
        .fu_data  (fu_data),
        .fu_spec  (fu_spec),
        .flush    (flush),
        .resolved (resolved),
        .wb_write (wb_write),
        .wb_sel   (wb_sel),
        .wb_data  (wb_data),
        .wb_tag   (wb_tag),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: one queue per FU holding accepted results in arrival order.
    typedef struct {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        bit                spec;
        bit                killed;
    } m_entry_t;

    m_entry_t          mq [NUM_FU][$];
    int                m_rr;
    logic              m_write;
    logic [REG_W-1:0]  m_sel;
    logic [DATA_W-1:0] m_data;
    logic [TAG_W-1:0]  m_tag;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) mq[i].delete();
        m_rr = 0;
        m_write = 1'b0;
        m_sel = '0;
        m_data = '0;
        m_tag = '0;
    endtask

    function automatic logic [NUM_FU-1:0] model_ready();
        logic [NUM_FU-1:0] r;
        for (int i = 0; i < NUM_FU; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    function automatic logic model_busy();
        logic b;
        b = m_write;
        for (int i = 0; i < NUM_FU; i++) if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic model_edge();
        logic [NUM_FU-1:0] rdy;
        int w;
        bit grant;
        m_entry_t e;
        rdy = model_ready();
        w = -1;
        for (int k = 0; k < NUM_FU; k++) begin
            int j;
            j = (m_rr + k) % NUM_FU;
            if (w < 0 && mq[j].size() > 0) begin
                if (!mq[j][0].killed) w = j;
            end
        end
        grant = (w >= 0);
        if (grant) begin
            if (flush && mq[w][0].spec) grant = 0;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (!(grant && i == w) && mq[i].size() > 0) begin
                if (mq[i][0].killed) e = mq[i].pop_front();
            end
        end
        if (grant) begin
            e = mq[w].pop_front();
            m_write = 1'b1;
            m_sel = e.rd;
            m_data = e.data;
            m_tag = TAG_W'(w);
            m_rr = (w + 1) % NUM_FU;
        end else begin
            m_write = 1'b0;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            for (int k = 0; k < mq[i].size(); k++) begin
                e = mq[i][k];
                if (flush) begin
                    if (e.spec) e.killed = 1;
                end else if (resolved) begin
                    e.spec = 0;
                end
                mq[i][k] = e;
            end
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && rdy[i] && !(flush && fu_spec[i])) begin
                e.rd = fu_rd[i*REG_W +: REG_W];
                e.data = fu_data[i*DATA_W +: DATA_W];
                e.spec = fu_spec[i] && !resolved;
                e.killed = 0;
                mq[i].push_back(e);
            end
        end
    endtask

    // Called at posedge+1: drive inputs, check ready, take the edge, check outputs.
    task automatic step(input logic [NUM_FU-1:0] v, input logic [NUM_FU-1:0] sp,
                        input logic fl, input logic rs,
                        input logic [NUM_FU*REG_W-1:0] rd, input logic [NUM_FU*DATA_W-1:0] d);
        fu_valid = v;
        fu_spec = sp;
        flush = fl;
        resolved = rs;
        fu_rd = rd;
        fu_data = d;
        #1;
        rdy_pre = fu_ready;
        chk("fu_ready", 32'(fu_ready), 32'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk("wb_write", 32'(wb_write), 32'(m_write));
        chk("wb_sel", 32'(wb_sel), 32'(m_sel));
        chk("wb_data", wb_data, m_data);
        chk("wb_tag", 32'(wb_tag), 32'(m_tag));
        chk("busy", 32'(busy), 32'(model_busy()));
    endtask

    task automatic idle();
        step('0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        fu_valid = '0;
        fu_spec = '0;
        flush = 1'b0;
        resolved = 1'b0;
        #1;
        chk("rst_wb_write", 32'(wb_write), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wb_sel", 32'(wb_sel), 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_tag", 32'(wb_tag), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(fu_ready), 32'h7);
    endtask

    typedef struct {
        logic [NUM_FU-1:0] valid;
        logic [NUM_FU-1:0] exp_ready;
        logic              exp_write;
        logic [REG_W-1:0]  exp_sel;
        logic [TAG_W-1:0]  exp_tag;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [NUM_FU*REG_W-1:0]  rdv;
        logic [NUM_FU*DATA_W-1:0] dv;
        bit drained;

        // All FUs valid every cycle from rr=0; row r, FU i carries rd=3r+i+1, data=0x100*r+i.
        tbl[0] = '{3'b111, 3'b111, 1'b0, 5'd0, 2'd0, 32'h000};
        tbl[1] = '{3'b111, 3'b111, 1'b1, 5'd1, 2'd0, 32'h000};
        tbl[2] = '{3'b111, 3'b001, 1'b1, 5'd2, 2'd1, 32'h001};
        tbl[3] = '{3'b111, 3'b010, 1'b1, 5'd3, 2'd2, 32'h002};
        tbl[4] = '{3'b111, 3'b100, 1'b1, 5'd4, 2'd0, 32'h100};
        tbl[5] = '{3'b111, 3'b001, 1'b1, 5'd5, 2'd1, 32'h101};
        tbl[6] = '{3'b111, 3'b010, 1'b1, 5'd6, 2'd2, 32'h102};

        #3;
        reset_mid();

        // Single uncontended result from FU1.
        step(3'b010, 3'b000, 1'b0, 1'b0, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEAD, 32'h0});
        chk("t1_no_early_write", 32'(wb_write), 32'h0);
        idle();
        chk("t1_write", 32'(wb_write), 32'h1);
        chk("t1_sel", 32'(wb_sel), 32'd5);
        chk("t1_data", wb_data, 32'hDEAD);
        chk("t1_tag", 32'(wb_tag), 32'd1);
        idle();
        chk("t1_write_drop", 32'(wb_write), 32'h0);
        chk("t1_sel_hold", 32'(wb_sel), 32'd5);

        reset_mid();
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                rdv[i*REG_W +: REG_W] = REG_W'(r*3 + i + 1);
                dv[i*DATA_W +: DATA_W] = DATA_W'(256*r + i);
            end
            step(tbl[r].valid, '0, 1'b0, 1'b0, rdv, dv);
            chk("tbl_ready", 32'(rdy_pre), 32'(tbl[r].exp_ready));
            chk("tbl_write", 32'(wb_write), 32'(tbl[r].exp_write));
            chk("tbl_sel", 32'(wb_sel), 32'(tbl[r].exp_sel));
            chk("tbl_tag", 32'(wb_tag), 32'(tbl[r].exp_tag));
            chk("tbl_data", wb_data, tbl[r].exp_data);
        end

        // FU0 now holds DEPTH entries; reset in the middle of the stream.
        chk("t6_full_ready0", 32'(fu_ready[0]), 32'h0);
        chk("t6_write_before", 32'(wb_write), 32'h1);
        reset_mid();

        // Spec rd7 ahead of non-spec rd3 in FU0, flush as rd3 arrives.
        step(3'b001, 3'b001, 1'b0, 1'b0, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77});
        step(3'b001, 3'b000, 1'b1, 1'b0, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h33});
        chk("t3_flush_nogrant", 32'(wb_write), 32'h0);
        idle();
        chk("t3_killed_silent", 32'(wb_write), 32'h0);
        idle();
        chk("t3_rd3_write", 32'(wb_write), 32'h1);
        chk("t3_rd3_sel", 32'(wb_sel), 32'd3);
        idle();

        // Resolve clears spec on FU2's rd9 before a later flush.
        reset_mid();
        step(3'b111, 3'b100, 1'b0, 1'b0, {5'd9, 5'd2, 5'd1}, {32'h99, 32'h22, 32'h11});
        step('0, '0, 1'b0, 1'b1, '0, '0);
        step('0, '0, 1'b1, 1'b0, '0, '0);
        idle();
        chk("t4_rd9_write", 32'(wb_write), 32'h1);
        chk("t4_rd9_sel", 32'(wb_sel), 32'd9);
        chk("t4_rd9_tag", 32'(wb_tag), 32'd2);

        // Flush and resolve on the same edge: flush wins and rd4 dies.
        reset_mid();
        step(3'b111, 3'b100, 1'b0, 1'b0, {5'd4, 5'd2, 5'd1}, {32'h44, 32'h22, 32'h11});
        step('0, '0, 1'b1, 1'b1, '0, '0);
        chk("t5_fu0_sel", 32'(wb_sel), 32'd1);
        idle();
        chk("t5_fu1_sel", 32'(wb_sel), 32'd2);
        idle();
        chk("t5_no_rd4", 32'(wb_write), 32'h0);
        chk("t5_idle_busy", 32'(busy), 32'h0);
        chk("t5_sel_hold", 32'(wb_sel), 32'd2);

        // Random traffic against the model.
        reset_mid();
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                rdv[i*REG_W +: REG_W] = REG_W'($urandom);
                dv[i*DATA_W +: DATA_W] = $urandom;
            end
            step(NUM_FU'($urandom_range(0, 7)), NUM_FU'($urandom_range(0, 7)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), rdv, dv);
        end
        drained = 0;
        for (int n = 0; n < 40 && !drained; n++) begin
            idle();
            if (!busy) drained = 1;
        end
        chk("drain_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
